// File: rtl/dcache_controller_if.sv
// CPU-side and memory-side signal bundle for the L1 data cache.
// The cache takes the slave view; the pipeline/memory environment takes the master view.
interface dcache_controller_if;
   logic [31:0]  cpu_addr_i;
   logic [31:0]  cpu_data_i;
   logic         cpu_MemRead_i;
   logic         cpu_MemWrite_i;
   logic [31:0]  cpu_data_o;
   logic         cpu_stall_o;
   logic [31:0]  mem_addr_o;
   logic [255:0] mem_data_o;
   logic         mem_enable_o;
   logic         mem_write_o;
   logic [255:0] mem_data_i;
   logic         mem_ack_i;

   modport slave (
      input  cpu_addr_i, cpu_data_i, cpu_MemRead_i, cpu_MemWrite_i, mem_data_i, mem_ack_i,
      output cpu_data_o, cpu_stall_o, mem_addr_o, mem_data_o, mem_enable_o, mem_write_o
   );

   modport master (
      output cpu_addr_i, cpu_data_i, cpu_MemRead_i, cpu_MemWrite_i, mem_data_i, mem_ack_i,
      input  cpu_data_o, cpu_stall_o, mem_addr_o, mem_data_o, mem_enable_o, mem_write_o
   );
endinterface

// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate L1 data cache.
// Hits complete in the request cycle; misses stall the pipeline through an
// optional write-back of a dirty victim, a line refill, and a fill cycle.
module dcache_controller #(
   parameter int INDEX_BITS = 4
) (
   input logic clk_i,
   input logic rst_i,
   dcache_controller_if.slave bus
);
   localparam int LINES    = 1 << INDEX_BITS;
   localparam int TAG_BITS = 27 - INDEX_BITS;

   typedef enum logic [1:0] {IDLE, WB, REFILL, FILL} state_t;

   state_t state, state_next;

   // Request decode
   logic [TAG_BITS-1:0]   req_tag;
   logic [INDEX_BITS-1:0] req_index;
   logic [2:0]            req_word;
   logic                  access;
   logic                  is_store;
   logic                  is_load;
   logic                  hit;
   logic                  victim_dirty;
   logic                  write_hit;
   logic                  unused_byte_bits;

   // Line storage
   logic [LINES-1:0]    valid;
   logic [LINES-1:0]    dirty;
   logic [TAG_BITS-1:0] tags  [LINES];
   logic [255:0]        lines [LINES];
   logic [255:0]        fill_line;

   // Outputs before they reach the interface
   logic         stall;
   logic [31:0]  load_data;
   logic         mem_enable;
   logic         mem_write;
   logic [31:0]  mem_addr;
   logic [255:0] mem_data;

   assign req_tag   = bus.cpu_addr_i[31:5+INDEX_BITS];
   assign req_index = bus.cpu_addr_i[4+INDEX_BITS:5];
   assign req_word  = bus.cpu_addr_i[4:2];

   // Word accesses only: the byte offset carries no information.
   assign unused_byte_bits = ^bus.cpu_addr_i[1:0];

   assign access       = bus.cpu_MemRead_i | bus.cpu_MemWrite_i;
   // A request with both controls high behaves as a store.
   assign is_store     = bus.cpu_MemWrite_i;
   assign is_load      = bus.cpu_MemRead_i & ~bus.cpu_MemWrite_i;
   assign hit          = valid[req_index] & (tags[req_index] == req_tag);
   assign victim_dirty = valid[req_index] & dirty[req_index];
   assign write_hit    = (state == IDLE) & is_store & hit;

   // State register
   always_ff @(posedge clk_i) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples
      // pre-edge values; blocking here would create order-dependent simulation.
      if (rst_i) state <= IDLE;
      else       state <= state_next;
   end

   // Next-state decode plus the combinational CPU-side outputs
   always_comb begin
      // NOTE: every output gets a default first so no path through the case
      // leaves a signal unassigned, which would otherwise infer a latch.
      state_next = state;
      stall      = 1'b0;
      load_data  = 32'h0;
      case (state)
         IDLE: begin
            if (access && !hit) begin
               stall      = 1'b1;
               state_next = victim_dirty ? WB : REFILL;
            end else if (is_load && hit) begin
               load_data = lines[req_index][{req_word, 5'd0} +: 32];
            end
         end
         WB: begin
            stall = 1'b1;
            if (bus.mem_ack_i) state_next = REFILL;
         end
         REFILL: begin
            stall = 1'b1;
            if (bus.mem_ack_i) state_next = FILL;
         end
         FILL: begin
            stall      = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Registered memory request; held stable until the memory acknowledges
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         mem_enable <= 1'b0;
         mem_write  <= 1'b0;
         mem_addr   <= 32'h0;
         mem_data   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (state_next == WB) begin
                  mem_enable <= 1'b1;
                  mem_write  <= 1'b1;
                  mem_addr   <= {tags[req_index], req_index, 5'd0};
                  mem_data   <= lines[req_index];
               end else if (state_next == REFILL) begin
                  mem_enable <= 1'b1;
                  mem_write  <= 1'b0;
                  mem_addr   <= {req_tag, req_index, 5'd0};
               end
            end
            WB: begin
               if (bus.mem_ack_i) begin
                  mem_write <= 1'b0;
                  mem_addr  <= {req_tag, req_index, 5'd0};
               end
            end
            REFILL: begin
               if (bus.mem_ack_i) mem_enable <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   // Capture the refill line when memory delivers it
   always_ff @(posedge clk_i) begin
      if (state == REFILL && bus.mem_ack_i) fill_line <= bus.mem_data_i;
   end

   // Valid and dirty bookkeeping
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         valid <= '0;
         dirty <= '0;
      end else if (state == FILL) begin
         valid[req_index] <= 1'b1;
         dirty[req_index] <= 1'b0;
      end else if (write_hit) begin
         dirty[req_index] <= 1'b1;
      end
   end

   // Tag and data arrays: written on fill and on store hits
   always_ff @(posedge clk_i) begin
      // NOTE: tag/data arrays are deliberately not reset; valid bits gate every use,
      // and leaving them reset-free lets them map onto RAM.
      if (state == FILL) begin
         tags[req_index]  <= req_tag;
         lines[req_index] <= fill_line;
      end else if (write_hit) begin
         lines[req_index][{req_word, 5'd0} +: 32] <= bus.cpu_data_i;
      end
   end

   assign bus.cpu_stall_o  = stall;
   assign bus.cpu_data_o   = load_data;
   assign bus.mem_enable_o = mem_enable;
   assign bus.mem_write_o  = mem_write;
   assign bus.mem_addr_o   = mem_addr;
   assign bus.mem_data_o   = mem_data;
endmodule

// File: tb/tb_dcache_controller.sv
// Self-checking bench for dcache_controller: a CPU-visible flat memory model plus
// a per-index residency model predict load data, stall length and memory traffic.
module tb_dcache_controller;
   localparam int IB = 4;

   typedef struct {
      logic [31:0]  addr;
      bit           write;
      logic [255:0] data;
   } req_t;

   logic clk;
   logic rst;

   dcache_controller_if bus ();

   dcache_controller #(.INDEX_BITS(IB)) dut (
      .clk_i(clk),
      .rst_i(rst),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Behavioural model state
   logic [255:0] backing [logic [31:0]];  // off-chip memory contents
   logic [255:0] view    [logic [31:0]];  // what the CPU must observe
   bit           res_valid [16];
   bit           res_dirty [16];
   int unsigned  res_tag   [16];
   req_t         exp_q[$];
   req_t         log_q[$];

   // Access bookkeeping shared with the compare process
   bit          checking = 1'b0;
   bit          in_acc   = 1'b0;
   int          penalty  = 0;
   int          cyc      = 0;
   logic [31:0] cur_exp_data = 32'h0;
   int          last_stall = 0;
   logic [31:0] last_data  = 32'h0;
   int          mem_lat    = 1;

   task automatic check(string name, logic [255:0] act, logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic logic [255:0] init_line(logic [31:0] la);
      logic [255:0] l;
      for (int w = 0; w < 8; w++) l[w*32 +: 32] = (la + 32'(w * 4)) ^ 32'hA5C3_0F1E;
      return l;
   endfunction

   function automatic logic [255:0] get_view(logic [31:0] la);
      return view.exists(la) ? view[la] : init_line(la);
   endfunction

   function automatic logic [255:0] get_backing(logic [31:0] la);
      return backing.exists(la) ? backing[la] : init_line(la);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 16; i++) begin
         res_valid[i] = 1'b0;
         res_dirty[i] = 1'b0;
      end
      view = backing;
      exp_q.delete();
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      bus.cpu_MemRead_i  = 1'b0;
      bus.cpu_MemWrite_i = 1'b0;
      in_acc = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   task automatic idle(int n);
      repeat (n) begin
         @(negedge clk);
         bus.cpu_MemRead_i  = 1'b0;
         bus.cpu_MemWrite_i = 1'b0;
      end
   endtask

   // One CPU access: predict traffic and timing, drive it, wait for completion.
   task automatic issue(bit rd, bit wr, logic [31:0] addr, logic [31:0] data, int lat);
      logic [31:0]  la  = {addr[31:5], 5'd0};
      int unsigned  idx = (addr >> 5) % 16;
      int unsigned  tag = addr >> (5 + IB);
      int unsigned  w   = (addr >> 2) % 8;
      bit           hit = res_valid[idx] && (res_tag[idx] == tag);
      logic [255:0] line;
      logic [31:0]  vla;
      @(negedge clk);
      mem_lat = lat;
      if (hit) begin
         penalty = 0;
      end else begin
         if (res_valid[idx] && res_dirty[idx]) begin
            vla = (res_tag[idx] << (5 + IB)) | (idx << 5);
            exp_q.push_back('{vla, 1'b1, get_view(vla)});
            penalty = 2 + 2 * lat;
         end else begin
            penalty = 2 + lat;
         end
         exp_q.push_back('{la, 1'b0, 256'h0});
         res_valid[idx] = 1'b1;
         res_tag[idx]   = tag;
         res_dirty[idx] = 1'b0;
      end
      line = get_view(la);
      cur_exp_data = (rd && !wr) ? line[w*32 +: 32] : 32'h0;
      if (wr) begin
         line[w*32 +: 32] = data;
         view[la] = line;
         res_dirty[idx] = 1'b1;
      end
      bus.cpu_addr_i     = addr;
      bus.cpu_data_i     = data;
      bus.cpu_MemRead_i  = rd;
      bus.cpu_MemWrite_i = wr;
      cyc    = 0;
      in_acc = 1'b1;
      for (int i = 0; i < 400 && in_acc; i++) @(posedge clk);
      if (in_acc) begin
         checks++;
         failures++;
         $display("FAIL access_timeout: addr=%0h still stalled after 400 cycles, required completion", addr);
         in_acc = 1'b0;
      end
      check("req_outstanding", 256'(exp_q.size()), 256'h0);
      idle(1);
   endtask

   // Compare process: CPU-side outputs every cycle against the model
   initial begin
      bit exp_stall;
      forever begin
         @(negedge clk);
         #2;
         if (checking) begin
            if (!in_acc) begin
               check("idle_stall", 256'(bus.cpu_stall_o), 256'h0);
               check("idle_data", 256'(bus.cpu_data_o), 256'h0);
            end else begin
               exp_stall = (cyc < penalty);
               check("stall", 256'(bus.cpu_stall_o), 256'(exp_stall));
               check("load_data", 256'(bus.cpu_data_o), exp_stall ? 256'h0 : 256'(cur_exp_data));
               if (!exp_stall) begin
                  last_stall = cyc;
                  last_data  = bus.cpu_data_o;
                  in_acc     = 1'b0;
               end
               cyc++;
            end
         end
      end
   end

   // Memory responder: ack after mem_lat cycles, check each request and its stability
   initial begin
      int           cnt = 0;
      bit           prev_en = 1'b0;
      bit           prev_ack = 1'b0;
      bit           prev_wr = 1'b0;
      logic [31:0]  prev_addr = 32'h0;
      logic [255:0] prev_data = '0;
      req_t         e;
      bus.mem_ack_i  = 1'b0;
      bus.mem_data_i = '0;
      forever begin
         @(negedge clk);
         #1;
         bus.mem_ack_i = 1'b0;
         if (rst) begin
            cnt     = 0;
            prev_en = 1'b0;
         end else begin
            if (bus.mem_enable_o) begin
               if (prev_en && !prev_ack) begin
                  check("mem_addr_stable", 256'(bus.mem_addr_o), 256'(prev_addr));
                  check("mem_write_stable", 256'(bus.mem_write_o), 256'(prev_wr));
                  if (prev_wr) check("mem_data_stable", bus.mem_data_o, prev_data);
               end
               cnt++;
               if (cnt >= mem_lat) begin
                  cnt = 0;
                  bus.mem_ack_i = 1'b1;
                  log_q.push_back('{bus.mem_addr_o, bus.mem_write_o, bus.mem_data_o});
                  if (exp_q.size() == 0) begin
                     checks++;
                     failures++;
                     $display("FAIL unexpected_req: addr=%0h write=%0d, required no request",
                              bus.mem_addr_o, bus.mem_write_o);
                  end else begin
                     e = exp_q.pop_front();
                     check("req_addr", 256'(bus.mem_addr_o), 256'(e.addr));
                     check("req_write", 256'(bus.mem_write_o), 256'(e.write));
                     if (e.write) check("wb_data", bus.mem_data_o, e.data);
                  end
                  if (bus.mem_write_o) backing[bus.mem_addr_o] = bus.mem_data_o;
                  else bus.mem_data_i = get_backing(bus.mem_addr_o);
               end
            end else begin
               cnt = 0;
            end
            prev_en = bus.mem_enable_o;
         end
         prev_ack  = bus.mem_ack_i;
         prev_wr   = bus.mem_write_o;
         prev_addr = bus.mem_addr_o;
         prev_data = bus.mem_data_o;
      end
   end

   // Watchdog
   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   // Main stimulus
   initial begin
      logic [255:0] l;
      int           s1;
      int           s2;
      bit           rd;
      bit           wr;
      int           op;
      logic [31:0]  a;

      rst = 1'b1;
      bus.cpu_addr_i     = 32'h0;
      bus.cpu_data_i     = 32'h0;
      bus.cpu_MemRead_i  = 1'b0;
      bus.cpu_MemWrite_i = 1'b0;
      model_reset();
      l = init_line(32'h100);
      l[63:32] = 32'hDEAD_BEEF;
      backing[32'h100] = l;
      view[32'h100]    = l;

      // Reset values
      repeat (2) @(posedge clk);
      #1;
      check("rst_mem_enable", 256'(bus.mem_enable_o), 256'h0);
      check("rst_mem_write", 256'(bus.mem_write_o), 256'h0);
      check("rst_mem_addr", 256'(bus.mem_addr_o), 256'h0);
      check("rst_mem_data", bus.mem_data_o, 256'h0);
      check("rst_stall", 256'(bus.cpu_stall_o), 256'h0);
      check("rst_cpu_data", 256'(bus.cpu_data_o), 256'h0);
      @(negedge clk);
      rst = 1'b0;
      checking = 1'b1;

      // 1: cold load miss, latency 3
      log_q.delete();
      issue(1, 0, 32'h0000_0104, 32'h0, 3);
      check("t1_stall_len", 256'(last_stall), 256'd5);
      check("t1_data", 256'(last_data), 256'hDEAD_BEEF);
      check("t1_req_count", 256'(log_q.size()), 256'd1);
      check("t1_req_addr", 256'(log_q[0].addr), 256'h100);
      check("t1_req_write", 256'(log_q[0].write), 256'h0);

      // 2: hit in the same line, no traffic
      log_q.delete();
      issue(1, 0, 32'h0000_0108, 32'h0, 3);
      check("t2_stall_len", 256'(last_stall), 256'd0);
      check("t2_req_count", 256'(log_q.size()), 256'd0);

      // 3: store hit, then a conflicting load forces write-back
      issue(0, 1, 32'h0000_0100, 32'h1234_5678, 2);
      log_q.delete();
      issue(1, 0, 32'h0000_0300, 32'h0, 2);
      check("t3_stall_len", 256'(last_stall), 256'd6);
      check("t3_req_count", 256'(log_q.size()), 256'd2);
      check("t3_wb_addr", 256'(log_q[0].addr), 256'h100);
      check("t3_wb_write", 256'(log_q[0].write), 256'h1);
      check("t3_wb_word0", 256'(log_q[0].data[31:0]), 256'h1234_5678);
      check("t3_rf_addr", 256'(log_q[1].addr), 256'h300);
      check("t3_rf_write", 256'(log_q[1].write), 256'h0);

      // 4: clean-victim misses at latency 1 and 10
      issue(1, 0, 32'h0000_0400, 32'h0, 1);
      s1 = last_stall;
      issue(1, 0, 32'h0000_0800, 32'h0, 10);
      s2 = last_stall;
      check("t4_stall_lat1", 256'(s1), 256'd3);
      check("t4_stall_diff", 256'(s2 - s1), 256'd9);

      // 5: reset during REFILL
      checking = 1'b0;
      @(negedge clk);
      mem_lat = 10;
      bus.cpu_addr_i     = 32'h0000_0600;
      bus.cpu_MemRead_i  = 1'b1;
      bus.cpu_MemWrite_i = 1'b0;
      repeat (3) @(negedge clk);
      #2;
      check("t5_refill_enable", 256'(bus.mem_enable_o), 256'h1);
      check("t5_refill_write", 256'(bus.mem_write_o), 256'h0);
      check("t5_refill_addr", 256'(bus.mem_addr_o), 256'h600);
      check("t5_refill_stall", 256'(bus.cpu_stall_o), 256'h1);
      rst = 1'b1;
      bus.cpu_MemRead_i = 1'b0;
      @(posedge clk);
      #1;
      check("t5_enable_after_rst", 256'(bus.mem_enable_o), 256'h0);
      check("t5_stall_after_rst", 256'(bus.cpu_stall_o), 256'h0);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      checking = 1'b1;
      log_q.delete();
      issue(1, 0, 32'h0000_0600, 32'h0, 2);
      check("t5_reload_stall", 256'(last_stall), 256'd4);
      check("t5_reload_reqs", 256'(log_q.size()), 256'd1);

      // 6: MemRead and MemWrite together on a hit act as a store
      issue(1, 0, 32'h0000_0500, 32'h0, 2);
      issue(1, 1, 32'h0000_0504, 32'hCAFE_F00D, 2);
      check("t6_hit_stall", 256'(last_stall), 256'd0);
      log_q.delete();
      issue(1, 0, 32'h0000_0104, 32'h0, 2);
      check("t6_req_count", 256'(log_q.size()), 256'd2);
      check("t6_wb_addr", 256'(log_q[0].addr), 256'h500);
      check("t6_wb_write", 256'(log_q[0].write), 256'h1);
      check("t6_wb_word1", 256'(log_q[0].data[63:32]), 256'hCAFE_F00D);

      // Randomized traffic over a small address space to force conflicts
      for (int n = 0; n < 400; n++) begin
         op = $urandom_range(0, 9);
         rd = (op < 5) || (op >= 8);
         wr = (op >= 5);
         a  = ($urandom_range(0, 3) << 9) | ($urandom_range(0, 15) << 5) |
              ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
         issue(rd, wr, a, $urandom(), $urandom_range(1, 4));
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      end

      // A reset after random traffic discards dirty lines; reads must see memory again
      do_reset();
      for (int n = 0; n < 40; n++) begin
         a = ($urandom_range(0, 3) << 9) | ($urandom_range(0, 15) << 5) | ($urandom_range(0, 7) << 2);
         issue(1, 0, a, 32'h0, $urandom_range(1, 3));
      end

      checking = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/dcache_controller.md
Name: dcache_controller

Overview:
Direct-mapped, write-back, write-allocate L1 data cache between the pipeline's MEM stage and off-chip data memory.
- CPU side: the MEM stage address, write data and MemRead/MemWrite controls connect here.
- Memory side: a 256-bit line port with an enable/ack handshake.
- On a miss, cpu_stall_o holds the whole pipeline until the line is refilled. The access then completes as a hit.

Parameters:
INDEX_BITS, 4, number of lines = 2^INDEX_BITS (default 16). Tag width = 27 - INDEX_BITS.

Ports:
clk_i  input  1  clock
rst_i  input  1  synchronous, active-high reset
cpu_addr_i  input  32  byte address from EX/MEM (ALU result)
cpu_data_i  input  32  store data
cpu_MemRead_i  input  1  load request
cpu_MemWrite_i  input  1  store request
cpu_data_o  output  32  load data
cpu_stall_o  output  1  freeze pipeline while high
mem_addr_o  output  32  line-aligned memory address
mem_data_o  output  256  line being written back
mem_enable_o  output  1  memory request
mem_write_o  output  1  1 = write-back, 0 = refill read
mem_data_i  input  256  refill line
mem_ack_i  input  1  one-cycle completion pulse from memory

Behaviour:
- Address split:
  - offset [4:0]; word select [4:2]; byte bits [1:0] are ignored (word accesses only).
  - index [4+INDEX_BITS:5]; tag [31:5+INDEX_BITS].
- Per-line storage: valid, dirty, tag, 256-bit data. All valid and dirty bits clear on reset. Data and tag contents are don't-care after reset.
- Access rules:
  - access = cpu_MemRead_i | cpu_MemWrite_i.
  - hit = valid & tag match; computed combinationally in IDLE.
  - If both request inputs are high, the access is treated as a store.
- Read hit:
  - cpu_data_o = selected word in the same cycle; zero latency, no stall.
  - cpu_data_o = 0 when there is no read hit.
- Write hit: the word is updated at the clock edge and dirty is set. No stall.
- Stall: cpu_stall_o = (state==IDLE & access & !hit) | (state!=IDLE). It is combinational. The CPU holds its request stable while stalled.
- FSM states: IDLE, WB, REFILL, FILL.
  - IDLE: on access & !hit, go to WB if the victim is valid & dirty; otherwise go to REFILL.
  - WB: mem_enable_o=1, mem_write_o=1, mem_addr_o = {victim tag, index, 5'b0}, mem_data_o = victim line. On mem_ack_i go to REFILL.
  - REFILL: mem_enable_o=1, mem_write_o=0, mem_addr_o = {req tag, index, 5'b0}. On mem_ack_i, capture mem_data_i and go to FILL.
  - FILL: write the captured line with the new tag; valid=1, dirty=0. Go to IDLE. The next cycle re-evaluates as a hit and drops the stall in that cycle.
- Memory-side outputs are registered/state-decoded and held stable while mem_enable_o=1 and no ack has arrived. Memory latency is any value ≥1 cycle.
- mem_ack_i is ignored in IDLE and FILL.
- Reset values: mem_enable_o=0, mem_write_o=0, mem_addr_o=0, mem_data_o=0, cpu_stall_o=0 (no access), cpu_data_o=0, state=IDLE.
- Reset mid-operation: at the reset edge the FSM returns to IDLE and all valid/dirty bits clear. Any dirty data in flight is discarded. mem_enable_o is low in the cycle after the edge.
- Stall timing:
  - Miss penalty with a clean victim = 1 (IDLE detect) + refill latency + 1 (FILL). The access completes in the following cycle.
  - A dirty victim adds the write-back latency.
- Conflict: two addresses with the same index and different tags evict each other. No associativity.

Test Plan:
1. Reset, then load 0x0000_0104 with memory line 0x100 word1 = 0xDEAD_BEEF and ack latency 3 -> stall asserted; one REFILL request at mem_addr_o=0x100 with mem_write_o=0; next cycle read hit returns 0xDEAD_BEEF with stall low.
2. Load 0x0000_0108 right after scenario 1 -> hit; data returned in the same cycle; no memory request.
3. Store 0x1234_5678 to 0x0000_0100 (hit), then load 0x0000_0300 (same index 8, tag differs) -> WB at mem_addr_o=0x100 with mem_data_o[31:0]=0x1234_5678, then REFILL at 0x300.
4. Load a clean-victim miss with ack latency 1, then 10 -> stall lengths differ by exactly 9 cycles; mem_addr_o stays stable until ack.
5. Assert rst_i during REFILL -> mem_enable_o=0 the next cycle; reload of the same address misses again.
6. Assert MemRead and MemWrite together on a hit -> line updated, dirty set; subsequent eviction performs a write-back.
